// File: rtl/round_sequencer.sv
// Match-level controller: START -> countdown -> play -> round end -> match end; optional macro ROUND_TIMEOUT_EN.
// Latency: state, scores and strobes update one clk after the triggering click/tick/collision; mode is a decode of state.
// Backpressure: none; inputs are sampled every cycle and are ignored in states where they have no meaning.

package round_sequencer_pkg;
  typedef enum logic [1:0] {
    START       = 2'd0,
    GAME        = 2'd1,
    PLAYER1_WIN = 2'd2,
    PLAYER2_WIN = 2'd3
  } game_mode;
endpackage

module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int CLK_FREQ     = 65_000_000,
  parameter int COUNTDOWN_S  = 3,
  parameter int ROUND_END_S  = 2,
  parameter int WIN_ROUNDS   = 3,
  parameter int ROUND_TIME_S = 60
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mouse_left,
  input  logic                             player1_collision,
  input  logic                             player2_collision,
  output game_mode                         mode,
  output logic                             round_active,
  output logic                             round_start,
  output logic [$clog2(COUNTDOWN_S+1)-1:0] countdown,
  output logic [3:0]                       p1_score,
  output logic [3:0]                       p2_score,
  output logic [3:0]                       round_num
);

  localparam int CNT_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int CD_W    = $clog2(COUNTDOWN_S + 1);
  localparam int SEC_MAX = (ROUND_END_S > ROUND_TIME_S) ? ROUND_END_S : ROUND_TIME_S;
  localparam int SECS_W  = $clog2(SEC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_ROUND_END = 3'd3,
    S_MATCH_END = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               mouse_left_q;
  logic               click_armed;
  logic               click;
  logic [CNT_W-1:0]   sec_cnt;
  logic [SECS_W-1:0]  secs;
  logic               sec_tick;
  logic               p1_wins_round;
  logic               p2_wins_round;
  logic               match_decided;

  // click_armed stays low for the first cycle after reset so a button held
  // through reset is absorbed into mouse_left_q instead of reading as a click
  assign click         = mouse_left & ~mouse_left_q & click_armed;
  assign sec_tick      = (sec_cnt == CNT_W'(CLK_FREQ - 1));
  assign match_decided = (p1_score == 4'(WIN_ROUNDS)) || (p2_score == 4'(WIN_ROUNDS));

  // Mouse edge detector registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mouse_left_q <= 1'b0;
      click_armed  <= 1'b0;
    end else begin
      mouse_left_q <= mouse_left;
      click_armed  <= 1'b1;
    end
  end

  // Second divider and per-state seconds count, both restarted on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_cnt <= '0;
      secs    <= '0;
    end else if (next_state != state) begin
      sec_cnt <= '0;
      secs    <= '0;
    end else if (sec_tick) begin
      sec_cnt <= '0;
      secs    <= secs + SECS_W'(1);
    end else begin
      sec_cnt <= sec_cnt + CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state logic and round outcome decode
  always_comb begin
    next_state    = state;
    p1_wins_round = 1'b0;
    p2_wins_round = 1'b0;
    case (state)
      S_IDLE: begin
        if (click) next_state = S_COUNTDOWN;
      end
      S_COUNTDOWN: begin
        if (sec_tick && countdown == CD_W'(1)) next_state = S_PLAY;
      end
      S_PLAY: begin
        // A player scores when only the opponent is hit; a double hit is a draw
        if (player1_collision || player2_collision) begin
          next_state    = S_ROUND_END;
          p1_wins_round = player2_collision & ~player1_collision;
          p2_wins_round = player1_collision & ~player2_collision;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (sec_tick && secs == SECS_W'(ROUND_TIME_S - 1)) begin
          next_state = S_ROUND_END;
        end
`endif
      end
      S_ROUND_END: begin
        if (sec_tick && secs == SECS_W'(ROUND_END_S - 1))
          next_state = match_decided ? S_MATCH_END : S_COUNTDOWN;
      end
      S_MATCH_END: begin
        if (click) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Registered outputs: strobes, countdown, scores and round number
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_active <= 1'b0;
      round_start  <= 1'b0;
      countdown    <= '0;
      p1_score     <= '0;
      p2_score     <= '0;
      round_num    <= '0;
    end else begin
      round_active <= (next_state == S_PLAY);
      round_start  <= (state == S_COUNTDOWN) && (next_state == S_PLAY);
      case (state)
        S_IDLE: begin
          if (next_state == S_COUNTDOWN) begin
            countdown <= CD_W'(COUNTDOWN_S);
            p1_score  <= '0;
            p2_score  <= '0;
            round_num <= 4'd1;
          end
        end
        S_COUNTDOWN: begin
          // The final decrement lands countdown on 0 as PLAY is entered
          if (sec_tick) countdown <= countdown - CD_W'(1);
        end
        S_PLAY: begin
          if (p1_wins_round) p1_score <= p1_score + 4'd1;
          if (p2_wins_round) p2_score <= p2_score + 4'd1;
        end
        S_ROUND_END: begin
          if (next_state == S_COUNTDOWN) begin
            countdown <= CD_W'(COUNTDOWN_S);
            if (round_num != 4'd15) round_num <= round_num + 4'd1;
          end
        end
        S_MATCH_END: begin
          if (next_state == S_IDLE) begin
            p1_score  <= '0;
            p2_score  <= '0;
            round_num <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Mode seen by the rendering blocks
  always_comb begin
    mode = START;
    case (state)
      S_IDLE:                          mode = START;
      S_COUNTDOWN, S_PLAY, S_ROUND_END: mode = GAME;
      S_MATCH_END:                     mode = (p1_score == 4'(WIN_ROUNDS)) ? PLAYER1_WIN : PLAYER2_WIN;
      default:                         mode = START;
    endcase
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with CLK_FREQ=10, COUNTDOWN_S=3, ROUND_END_S=1, WIN_ROUNDS=2.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Timeout scenario is compiled in only when ROUND_TIMEOUT_EN is defined (ROUND_TIME_S=2).

module tb_round_sequencer;
  import round_sequencer_pkg::*;

  logic       clk;
  logic       rst;
  logic       mouse_left;
  logic       player1_collision;
  logic       player2_collision;
  game_mode   mode;
  logic       round_active;
  logic       round_start;
  logic [1:0] countdown;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] round_num;

  int errors = 0;
  int checks = 0;

  round_sequencer #(
    .CLK_FREQ(10), .COUNTDOWN_S(3), .ROUND_END_S(1), .WIN_ROUNDS(2), .ROUND_TIME_S(2)
  ) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left),
    .player1_collision(player1_collision), .player2_collision(player2_collision),
    .mode(mode), .round_active(round_active), .round_start(round_start),
    .countdown(countdown), .p1_score(p1_score), .p2_score(p2_score), .round_num(round_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".mode"}, 32'(mode), 32'(START));
    chk({tag, ".round_active"}, 32'(round_active), 0);
    chk({tag, ".round_start"}, 32'(round_start), 0);
    chk({tag, ".countdown"}, 32'(countdown), 0);
    chk({tag, ".p1_score"}, 32'(p1_score), 0);
    chk({tag, ".p2_score"}, 32'(p2_score), 0);
    chk({tag, ".round_num"}, 32'(round_num), 0);
  endtask

  initial begin
    rst = 1'b0; mouse_left = 1'b0; player1_collision = 1'b0; player2_collision = 1'b0;
    #12;
    chk_reset_outputs("reset");
    #10 rst = 1'b1;
    tick(2);
    chk("idle.mode", 32'(mode), 32'(START));

    // ---- Match 1: player 2 takes it 2-0 ----
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    chk("click.mode", 32'(mode), 32'(GAME));
    chk("click.countdown", 32'(countdown), 3);
    chk("click.round_num", 32'(round_num), 1);
    tick(9);
    chk("cd.9.countdown", 32'(countdown), 3);
    tick(1);
    chk("cd.10.countdown", 32'(countdown), 2);
    tick(10);
    chk("cd.20.countdown", 32'(countdown), 1);
    tick(9);
    chk("cd.29.round_active", 32'(round_active), 0);
    chk("cd.29.round_start", 32'(round_start), 0);
    tick(1);
    chk("play.round_start", 32'(round_start), 1);
    chk("play.round_active", 32'(round_active), 1);
    chk("play.countdown", 32'(countdown), 0);
    tick(1);
    chk("play.round_start_one_cycle", 32'(round_start), 0);
    chk("play.round_active_held", 32'(round_active), 1);

    player1_collision = 1'b1;
    tick(1);
    player1_collision = 1'b0;
    chk("r1.p2_score", 32'(p2_score), 1);
    chk("r1.p1_score", 32'(p1_score), 0);
    chk("r1.round_active", 32'(round_active), 0);
    tick(9);
    chk("r1.end9.countdown", 32'(countdown), 0);
    chk("r1.end9.round_num", 32'(round_num), 1);
    tick(1);
    chk("r2.countdown", 32'(countdown), 3);
    chk("r2.round_num", 32'(round_num), 2);
    tick(30);
    chk("r2.round_start", 32'(round_start), 1);

    player1_collision = 1'b1;
    tick(1);
    player1_collision = 1'b0;
    chk("r2.p2_score", 32'(p2_score), 2);
    tick(9);
    chk("r2.end9.mode", 32'(mode), 32'(GAME));
    tick(1);
    chk("match1.mode", 32'(mode), 32'(PLAYER2_WIN));
    chk("match1.p2_score_hold", 32'(p2_score), 2);
    tick(5);
    chk("match1.mode_hold", 32'(mode), 32'(PLAYER2_WIN));
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    chk("match1.exit.mode", 32'(mode), 32'(START));
    chk("match1.exit.p2_score", 32'(p2_score), 0);

    // ---- Match 2: ignored collisions/clicks, a draw, then reset mid-play ----
    player1_collision = 1'b1;
    tick(2);
    player1_collision = 1'b0;
    chk("idle_coll.p2_score", 32'(p2_score), 0);
    chk("idle_coll.mode", 32'(mode), 32'(START));
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    player2_collision = 1'b1;
    tick(3);
    player2_collision = 1'b0;
    chk("cd_coll.p1_score", 32'(p1_score), 0);
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    chk("cd_click.mode", 32'(mode), 32'(GAME));
    chk("cd_click.countdown", 32'(countdown), 3);
    tick(26);
    chk("m2.play.round_active", 32'(round_active), 1);

    player1_collision = 1'b1; player2_collision = 1'b1;
    tick(1);
    player1_collision = 1'b0; player2_collision = 1'b0;
    chk("draw.p1_score", 32'(p1_score), 0);
    chk("draw.p2_score", 32'(p2_score), 0);
    chk("draw.round_active", 32'(round_active), 0);
    chk("draw.mode", 32'(mode), 32'(GAME));
    tick(10);
    chk("draw.next.countdown", 32'(countdown), 3);
    chk("draw.next.round_num", 32'(round_num), 2);
    tick(30);
    chk("m2.r2.round_active", 32'(round_active), 1);

    player2_collision = 1'b1;
    tick(1);
    player2_collision = 1'b0;
    chk("m2.r2.p1_score", 32'(p1_score), 1);
    tick(10);
    chk("m2.r3.round_num", 32'(round_num), 3);
    tick(30);
    chk("m2.r3.round_active", 32'(round_active), 1);
    chk("m2.r3.p1_score", 32'(p1_score), 1);

    rst = 1'b0;
    #2;
    chk_reset_outputs("async_rst");
    mouse_left = 1'b1;
    #2 rst = 1'b1;
    tick(3);
    chk("held_click.mode", 32'(mode), 32'(START));
    mouse_left = 1'b0;
    tick(2);
    chk("held_click.release.mode", 32'(mode), 32'(START));
    chk("held_click.countdown", 32'(countdown), 0);

`ifdef ROUND_TIMEOUT_EN
    // ---- Round timeout: 20 cycles of PLAY without a hit ends as a draw ----
    mouse_left = 1'b1;
    tick(1);
    mouse_left = 1'b0;
    tick(30);
    chk("to.round_active", 32'(round_active), 1);
    tick(19);
    chk("to.19.round_active", 32'(round_active), 1);
    tick(1);
    chk("to.20.round_active", 32'(round_active), 0);
    chk("to.20.mode", 32'(mode), 32'(GAME));
    chk("to.20.p1_score", 32'(p1_score), 0);
    chk("to.20.p2_score", 32'(p2_score), 0);
    tick(10);
    chk("to.next.round_num", 32'(round_num), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
